// File: rtl/ptfuse_loader.sv
// Serial fuse loader: shifts a bit stream into a 96-bit shadow row and commits
// each complete row atomically into the flattened product-term selection bitmap.
module ptfuse_loader #(
  parameter int NUM_PT   = 5,
  parameter int PT_WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  output logic                       cfg_ready,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic [0:NUM_PT*PT_WIDTH-1] ptbitmap_mux
);

  localparam int ROW_W = (NUM_PT > 1) ? $clog2(NUM_PT) : 1;
  localparam int BIT_W = $clog2(PT_WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_PT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  state_t              state;
  logic [0:PT_WIDTH-1] shadow;
  logic [ROW_W-1:0]    row_cnt;
  logic [BIT_W-1:0]    bit_cnt;

  // NOTE: all state, including handshake outputs, is updated with non-blocking
  // assignments so every register samples pre-edge values.
  // NOTE: the committed bitmap is reset too: an all-zero row grounds its
  // product term, so reset must land the array in that safe state at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      row_cnt      <= '0;
      bit_cnt      <= '0;
      ptbitmap_mux <= '0;
      cfg_ready    <= 1'b0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
    end else if (cfg_start) begin
      // Start overrides any beat or pending commit in the same cycle.
      state     <= SHIFT;
      shadow    <= '0;
      row_cnt   <= '0;
      bit_cnt   <= '0;
      cfg_ready <= 1'b1;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          if (cfg_valid) begin
            // First accepted bit migrates down to index 0 after a full row.
            shadow <= {shadow[1:PT_WIDTH-1], cfg_bit};
            if (bit_cnt == LAST_BIT) begin
              state     <= COMMIT;
              cfg_ready <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          ptbitmap_mux[int'(row_cnt)*PT_WIDTH +: PT_WIDTH] <= shadow;
          bit_cnt <= '0;
          if (row_cnt == LAST_ROW) begin
            state     <= DONE;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b1;
          end else begin
            row_cnt   <= row_cnt + 1'b1;
            state     <= SHIFT;
            cfg_ready <= 1'b1;
          end
        end
        default: ; // IDLE and DONE hold until start or reset
      endcase
    end
  end

endmodule

// File: tb/tb_ptfuse_loader.sv
// Randomized bench for ptfuse_loader against a queue-based row-assembly model.
module tb_ptfuse_loader;

  localparam int NUM_PT = 5;
  localparam int PTW    = 96;
  localparam int MAPW   = NUM_PT * PTW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_bit = 1'b0;
  logic            cfg_ready;
  logic            cfg_busy;
  logic            cfg_done;
  logic [0:MAPW-1] ptbitmap_mux;

  int total = 0;
  int bad   = 0;

  ptfuse_loader #(.NUM_PT(NUM_PT), .PT_WIDTH(PTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_bit      (cfg_bit),
    .cfg_ready    (cfg_ready),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .ptbitmap_mux (ptbitmap_mux)
  );

  always #5 clk = ~clk;

  // Reference model: a load is a list of accepted bits; every 96 of them form
  // a row that lands one cycle later in the next row slot.
  logic [0:MAPW-1] mdl_map;
  logic            mdl_q[$];
  int              mdl_row;
  bit              mdl_loading, mdl_commit, mdl_done, mdl_acc;

  task automatic check(input string tag, input logic [MAPW-1:0] got, input logic [MAPW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_map = '0; mdl_q.delete(); mdl_row = 0;
    mdl_loading = 0; mdl_commit = 0; mdl_done = 0; mdl_acc = 0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic b);
    mdl_acc = 0;
    if (s) begin
      mdl_q.delete(); mdl_row = 0; mdl_commit = 0; mdl_loading = 1; mdl_done = 0;
    end else if (mdl_commit) begin
      for (int i = 0; i < PTW; i++) mdl_map[mdl_row*PTW + i] = mdl_q[i];
      mdl_q.delete();
      mdl_commit = 0;
      if (mdl_row == NUM_PT - 1) begin
        mdl_loading = 0; mdl_done = 1;
      end else begin
        mdl_row++;
      end
    end else if (mdl_loading && v) begin
      mdl_q.push_back(b);
      mdl_acc = 1;
      if (mdl_q.size() == PTW) mdl_commit = 1;
    end
  endtask

  function automatic logic [0:PTW-1] dut_row(input int r);
    return ptbitmap_mux[r*PTW +: PTW];
  endfunction

  function automatic logic [0:PTW-1] mdl_row_val(input int r);
    return mdl_map[r*PTW +: PTW];
  endfunction

  task automatic compare_all();
    check("ready", MAPW'(cfg_ready), MAPW'(mdl_loading && !mdl_commit));
    check("busy",  MAPW'(cfg_busy),  MAPW'(mdl_loading));
    check("done",  MAPW'(cfg_done),  MAPW'(mdl_done));
    check("map",   ptbitmap_mux,     mdl_map);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check outputs.
  task automatic step(input logic s, input logic v, input logic b);
    cfg_start = s; cfg_valid = v; cfg_bit = b;
    @(posedge clk);
    model_edge(s, v, b);
    @(negedge clk);
    compare_all();
  endtask

  // Offer bits[0..n-1], each held until the model says it was accepted.
  task automatic send(input logic [0:MAPW-1] bits, input int n, input int gap_pct, output int cyc);
    int idx = 0;
    int guard = 0;
    cyc = 0;
    while (idx < n && guard < n * 60 + 100) begin
      step(1'b0, $urandom_range(0, 99) >= gap_pct, bits[idx]);
      cyc++;
      guard++;
      if (mdl_acc) idx++;
    end
    check("sent_all", MAPW'(idx), MAPW'(n));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", MAPW'(cfg_ready), '0);
    check("rst_busy",  MAPW'(cfg_busy),  '0);
    check("rst_done",  MAPW'(cfg_done),  '0);
    check("rst_map",   ptbitmap_mux,     '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [0:MAPW-1] stim;
  logic [0:PTW-1]  r0_prev, r1_prev, row_a;
  int              cyc;
  logic            hold_bit;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);  // valid in IDLE is ignored

    // Single row: 1 then 95 zeros; ready drops for exactly the COMMIT cycle.
    step(1'b1, 1'b0, 1'b0);
    stim = '0; stim[0] = 1'b1;
    send(stim, PTW, 0, cyc);
    check("ready_in_commit", MAPW'(cfg_ready), '0);
    step(1'b0, 1'b0, 1'b0);
    check("ready_after_commit", MAPW'(cfg_ready), MAPW'(1));
    row_a = '0; row_a[0] = 1'b1;
    check("row0_single", MAPW'(dut_row(0)), MAPW'(row_a));
    check("bit0", MAPW'(ptbitmap_mux[0]), MAPW'(1));

    // Full load, continuous valid, row r all ones except bit r*7.
    step(1'b1, 1'b0, 1'b0);
    stim = '1;
    for (int r = 0; r < NUM_PT; r++) stim[r*PTW + r*7] = 1'b0;
    send(stim, MAPW, 0, cyc);
    step(1'b0, 1'b1, 1'b0);
    cyc++;
    check("load_cycles", MAPW'(cyc), MAPW'(485));
    check("full_map", ptbitmap_mux, stim);
    for (int r = 0; r < NUM_PT; r++) begin
      row_a = '1; row_a[r*7] = 1'b0;
      check($sformatf("row%0d_pat", r), MAPW'(dut_row(r)), MAPW'(row_a));
    end
    repeat (4) step(1'b0, 1'b1, 1'b1);
    check("done_hold", MAPW'(cfg_done), MAPW'(1));
    check("ready_after_done", MAPW'(cfg_ready), '0);

    // Asynchronous reset mid-load clears everything immediately.
    step(1'b1, 1'b0, 1'b0);
    stim = '1;
    send(stim, 150, 0, cyc);
    pulse_reset();
    step(1'b0, 1'b0, 1'b0);

    // Restart mid-row: row 0 all ones, 40 bits of row 1, then start.
    step(1'b1, 1'b0, 1'b0);
    stim = '1;
    send(stim, PTW + 40, 0, cyc);
    step(1'b1, 1'b0, 1'b0);
    check("restart_row0", MAPW'(dut_row(0)), MAPW'({PTW{1'b1}}));
    check("restart_row1", MAPW'(dut_row(1)), '0);
    for (int i = 0; i < PTW; i++) stim[i] = 1'($urandom);
    row_a = stim[0:PTW-1];
    send(stim, PTW, 20, cyc);
    step(1'b0, 1'b0, 1'b0);
    check("reload_row0", MAPW'(dut_row(0)), MAPW'(row_a));
    check("reload_row1", MAPW'(dut_row(1)), '0);

    // Start coincident with COMMIT and a valid beat: no write, bit dropped.
    step(1'b1, 1'b0, 1'b0);
    r0_prev = mdl_row_val(0);
    r1_prev = mdl_row_val(1);
    for (int i = 0; i < PTW; i++) stim[i] = 1'($urandom);
    send(stim, PTW, 0, cyc);
    step(1'b1, 1'b1, 1'b1);
    check("no_commit_row0", MAPW'(dut_row(0)), MAPW'(r0_prev));
    for (int i = 0; i < PTW; i++) stim[i] = 1'($urandom);
    row_a = stim[0:PTW-1];
    send(stim, PTW, 0, cyc);
    step(1'b0, 1'b0, 1'b0);
    check("after_start_row0", MAPW'(dut_row(0)), MAPW'(row_a));
    check("after_start_row1", MAPW'(dut_row(1)), MAPW'(r1_prev));

    // Random traffic with occasional restarts; source holds unaccepted bits.
    hold_bit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (mdl_acc || !cfg_valid) hold_bit = 1'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 70, hold_bit);
    end

    // Final full load with random gaps, valid held across COMMIT cycles.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MAPW; i++) stim[i] = 1'($urandom);
    send(stim, MAPW, 40, cyc);
    step(1'b0, 1'b1, 1'b0);
    check("gap_done", MAPW'(cfg_done), MAPW'(1));
    check("gap_map", ptbitmap_mux, stim);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptfuse_loader.md
# ptfuse_loader

Serial fuse-configuration loader for a macrocell's product-term array. It accepts a bit stream over a valid/ready handshake, assembles it into 96-bit product-term selection rows, and commits each complete row atomically. It drives the flattened `ptbitmap_mux` selection vectors that the downstream `productinput` instances consume, one 96-bit slice per product term.

## Interface

- `NUM_PT`, default 5: product terms per macrocell, i.e. number of 96-bit rows.
- `PT_WIDTH`, default 96: bits per row (16 feedback + 40×2 UIM true/complement). Fixed at 96 in this design; exposed only for readability.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_start` input 1: one-cycle pulse; begins a (re)load at row 0.
- `cfg_valid` input 1: a `cfg_bit` value is offered this cycle.
- `cfg_bit` input 1: serial fuse bit.
- `cfg_ready` output 1: loader accepts a bit this cycle.
- `cfg_busy` output 1: load in progress (SHIFT or COMMIT).
- `cfg_done` output 1: all `NUM_PT` rows committed since the last `cfg_start`.
- `ptbitmap_mux` output `NUM_PT*96`, indexed `[0:NUM_PT*96-1]`: row r occupies `[r*96 : r*96+95]`, bit order identical to `productinput.ptbitmap_mux[0:95]`.

## Operation

- Row semantics: a bit value of 0 selects the input into the AND term; a value of 1 forces that AND input to 1. An all-zero row ANDs every UIM with its own complement, so pt = 0 (grounded term). This is the safe default.
- States: IDLE, SHIFT, COMMIT, DONE.
  - IDLE: `cfg_ready`=0. `cfg_start` → SHIFT with row_cnt=0 and bit_cnt=0.
  - SHIFT: `cfg_ready`=1. On `cfg_valid && cfg_ready`, the shadow register shifts toward index 0: shadow <= {shadow[1:95], cfg_bit}, and bit_cnt increments. The first bit accepted ends up at row index 0. On the beat with bit_cnt=95 → COMMIT.
  - COMMIT: one cycle, `cfg_ready`=0. Shadow is copied into row row_cnt in a single cycle, and bit_cnt clears. If row_cnt=`NUM_PT`-1 → DONE; otherwise row_cnt increments → SHIFT.
  - DONE: `cfg_ready`=0, `cfg_done`=1. Held until `cfg_start` or reset.
- `cfg_start` in any state, including mid-row or COMMIT:
  - Abandons the partial shadow and clears `cfg_done`.
  - Sets row_cnt=0 and bit_cnt=0; next state is SHIFT.
  - Already-committed rows keep their values until they are overwritten by new commits.
  - If `cfg_start` coincides with a COMMIT cycle, start wins and no row is written.
- `cfg_start` and `cfg_valid` asserted in the same cycle: start wins and the bit is dropped. `cfg_ready` must be 0 in that cycle when the state is not SHIFT. In SHIFT, the beat is discarded.
- `cfg_valid` while `cfg_ready`=0 has no effect. The source must hold the bit until it is accepted.
- A row in `ptbitmap_mux` changes only in COMMIT. Downstream never sees a partially shifted row.
- `cfg_busy` = (state == SHIFT or state == COMMIT).

## Timing

- Reset (`rst_n`=0, asynchronous): state=IDLE, `ptbitmap_mux`=all 0, shadow=0, counters=0, `cfg_ready`=0, `cfg_busy`=0, `cfg_done`=0. Reset asserted mid-load clears everything immediately, including committed rows.
- `cfg_start` sampled at edge n → `cfg_ready`=1 from cycle n+1.
- Throughput: 1 bit per cycle while valid. A row costs 96 accepted beats plus 1 COMMIT cycle.
- 96th beat of a row accepted at edge k:
  - `cfg_ready`=0 during cycle k+1 (COMMIT).
  - The row is visible on `ptbitmap_mux` from cycle k+2.
  - `cfg_ready` returns to 1 in cycle k+2 for a non-last row.
  - For the last row, `cfg_done`=1 from cycle k+2.
- Minimum full load with `cfg_valid` held high, `NUM_PT`=5: 5×97 = 485 cycles after the start cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset values: assert `rst_n`=0 asynchronously mid-cycle → `ptbitmap_mux`=0, `cfg_ready`=0, `cfg_done`=0 immediately, without waiting for a clock edge.
- Single-row ordering: start, then send 1 followed by 95 zeros → row 0 = bit0 set only (`ptbitmap_mux[0]`=1). Downstream `productinput` pt follows `mc_flb[0]`-independent logic per its selection. `cfg_ready` low for exactly one cycle after beat 96.
- Full load, `NUM_PT`=5, continuous valid, row r pattern = all 1 except bit r*7 → each slice matches its pattern. `cfg_done` rises at start+486 cycles (485-cycle load plus the start cycle). `cfg_ready` is 0 thereafter.
- Backpressure/gaps: random `cfg_valid` gaps plus valid held during COMMIT → no bit lost or duplicated; final bitmap equals the reference model.
- Restart mid-row: load row 0 as all ones, then 40 bits of row 1, then `cfg_start` → row 0 stays all ones until re-committed, row 1 stays 0, and the next 96 bits land in row 0.
- Start coincident with COMMIT and with a valid beat → no row write occurs, the bit is dropped, and bit_cnt=0 / row_cnt=0 afterwards.
